// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size and state encodings shared by the load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEM  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 4'd1;
      SZ_H:    size_bytes = 4'd2;
      SZ_W:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, byte enables, load extension and legality check
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_lane,
  output logic [XLEN-1:0]   rdata_ext,
  output logic              err
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  logic [OFF_W-1:0] off;
  logic [3:0]       nbytes;
  logic [XLEN-1:0]  rsh;
  logic             sign;

  assign off = addr_lo[OFF_W-1:0];

  always_comb begin
    nbytes     = size_bytes(size);
    be         = BE_W'(size_mask(size)) << off;
    wdata_lane = wdata << {off, 3'b000};
    rsh        = rdata >> {off, 3'b000};
    case (size)
      SZ_B:    sign = ~uns & rsh[7];
      SZ_H:    sign = ~uns & rsh[15];
      SZ_W:    sign = ~uns & rsh[31];
      default: sign = ~uns & rsh[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) begin
      rdata_ext[i] = (i < 8 * int'(nbytes)) ? rsh[i] : sign;
    end
    // dword has nbytes[2:0] == 0, so the alignment mask wraps to 3'b111
    err = ((addr_lo & (nbytes[2:0] - 3'd1)) != 3'd0) || (size == SZ_D && XLEN == 32);
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: request FSM, memory bus handshake and ack timeout
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state;
  logic              lat_we;
  logic              lat_uns;
  logic [1:0]        lat_size;
  logic [2:0]        lat_addr_lo;
  logic [XLEN-1:0]   lat_wdata;
  logic [CNT_W-1:0]  cnt;

  logic              in_idle;
  logic [XLEN/8-1:0] a_be;
  logic [XLEN-1:0]   a_wdata;
  logic [XLEN-1:0]   a_rdata;
  logic              a_err;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign in_idle = (state == ST_IDLE);

  lsu_align #(.XLEN(XLEN)) u_align (
    .size       (in_idle ? req_size     : lat_size),
    .uns        (in_idle ? req_unsigned : lat_uns),
    .addr_lo    (in_idle ? req_addr[2:0] : lat_addr_lo),
    .wdata      (in_idle ? req_wdata    : lat_wdata),
    .rdata      (mem_rdata),
    .be         (a_be),
    .wdata_lane (a_wdata),
    .rdata_ext  (a_rdata),
    .err        (a_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      lat_we      <= 1'b0;
      lat_uns     <= 1'b0;
      lat_size    <= SZ_B;
      lat_addr_lo <= '0;
      lat_wdata   <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_ready && req_valid) begin
            lat_we      <= req_we;
            lat_uns     <= req_unsigned;
            lat_size    <= req_size;
            lat_addr_lo <= req_addr[2:0];
            lat_wdata   <= req_wdata;
            cnt         <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            if (a_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ST_MEM;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              mem_be    <= a_be;
              mem_wdata <= a_wdata;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_MEM: begin
          if (mem_ack || (TIMEOUT > 0 && cnt == CNT_W'(TIMEOUT - 1))) begin
            state     <= ST_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~mem_ack;
            rsp_rdata <= (mem_ack && !lat_we) ? a_rdata : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu (XLEN=32, TIMEOUT=4)
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let it be accepted; returns #1 after the accept edge.
  task automatic accept(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    check("req_ready_before_accept", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  // Full access with mem_ack in the first mem_req cycle.
  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                      input logic [31:0] e_rdata);
    accept(we, size, uns, addr, wdata);
    check({tag, "_mem_req"}, mem_req, 1'b1);
    check({tag, "_mem_we"}, mem_we, we);
    check({tag, "_mem_addr"}, mem_addr, e_addr);
    check({tag, "_mem_be"}, mem_be, e_be);
    if (we) check({tag, "_mem_wdata"}, mem_wdata, e_wdata);
    check({tag, "_rsp_early"}, rsp_valid, 1'b0);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, e_rdata);
    check({tag, "_mem_req_drop"}, mem_req, 1'b0);
    tick();
    check({tag, "_rsp_one_cycle"}, rsp_valid, 1'b0);
    check({tag, "_ready_again"}, req_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    mem_rdata    = 32'h0;
    mem_ack      = 1'b0;
    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    reset = 1'b1;
    tick();
    check("ready_after_release", req_ready, 1'b1);

    xact("lw100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF,
         32'h100, 4'hF, 32'h0, 32'hDEADBEEF);
    xact("lb103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF,
         32'h100, 4'h8, 32'h0, 32'hFFFFFF80);
    xact("lbu103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF,
         32'h100, 4'h8, 32'h0, 32'h00000080);
    xact("lh102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80011234,
         32'h100, 4'hC, 32'h0, 32'hFFFF8001);
    xact("lhu102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80011234,
         32'h100, 4'hC, 32'h0, 32'h00008001);
    xact("sh202", 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234, 32'hFFFFFFFF,
         32'h200, 4'hC, 32'h12340000, 32'h0);
    xact("sb101", 1'b1, 2'b00, 1'b0, 32'h101, 32'hAB, 32'h0,
         32'h100, 4'h2, 32'h0000AB00, 32'h0);

    // Stray ack while idle must not produce a response.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_rsp", rsp_valid, 1'b0);
    check("idle_ack_busy", busy, 1'b0);

    // Misaligned word: error response, no bus access.
    accept(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    check("mis_mem_req", mem_req, 1'b0);
    check("mis_rsp_valid", rsp_valid, 1'b1);
    check("mis_rsp_err", rsp_err, 1'b1);
    check("mis_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    check("mis_rsp_one_cycle", rsp_valid, 1'b0);
    check("mis_mem_req_after", mem_req, 1'b0);

    // Dword on a 32-bit unit is illegal.
    tick();
    accept(1'b0, 2'b11, 1'b0, 32'h108, 32'h0);
    check("dw_mem_req", mem_req, 1'b0);
    check("dw_rsp_err", rsp_err, 1'b1);
    tick();
    tick();

    // Timeout: mem_req for exactly 4 cycles, then an error response.
    accept(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_mem_req_%0d", i), mem_req, 1'b1);
      check($sformatf("to_no_rsp_%0d", i), rsp_valid, 1'b0);
      if (i < 3) tick();
    end
    tick();
    check("to_mem_req_drop", mem_req, 1'b0);
    check("to_rsp_valid", rsp_valid, 1'b1);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    check("to_rsp_one_cycle", rsp_valid, 1'b0);

    // Reset two cycles into a memory wait.
    accept(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    tick();
    check("mid_mem_req", mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check("mid_ready_after", req_ready, 1'b1);
    xact("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11223344,
         32'h100, 4'hF, 32'h0, 32'h11223344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits; legal values 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the number of cycles to wait for mem_ack; 0 disables the timeout.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  clock, rising edge.
REQ-006 Port: reset  in  1  asynchronous reset, active-low.
REQ-007 Port: req_valid  in  1 / req_ready  out  1  request handshake from the datapath.
REQ-008 Port: req_we  in  1  1 = store, 0 = load.
REQ-009 Port: req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (legal only when XLEN=64).
REQ-010 Port: req_unsigned  in  1  zero-extend the load result.
REQ-011 Port: req_addr  in  ADDR_W / req_wdata  in  XLEN  byte address and store data (data in low bits).
REQ-012 Port: rsp_valid  out  1 / rsp_rdata  out  XLEN / rsp_err  out  1  one-cycle response.
REQ-013 Port: mem_req  out  1 / mem_we  out  1 / mem_addr  out  ADDR_W / mem_be  out  XLEN/8 / mem_wdata  out  XLEN  memory bus request.
REQ-014 Port: mem_rdata  in  XLEN / mem_ack  in  1  memory read data and completion.
REQ-015 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, MEM and RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: when req_valid is sampled high, the block SHALL latch all req_* inputs and go to MEM if the request is aligned and legal, otherwise go to RESP with the error flag set and make no memory access.
REQ-018 A request is misaligned when (addr mod bytes(size)) is not 0; size 11 with XLEN=32 is illegal; both cases SHALL set rsp_err.
REQ-019 MEM: mem_req SHALL stay at 1 and mem_we/addr/be/wdata SHALL stay stable until mem_ack is sampled high; then the block goes to RESP.
REQ-020 mem_addr SHALL be the latched address with its low log2(XLEN/8) bits cleared.
REQ-021 mem_be SHALL be the size mask (1, 3, 0xF, 0xFF) shifted left by the address byte offset.
REQ-022 mem_wdata SHALL be the store data shifted left by 8*offset.
REQ-023 Load data: the block SHALL shift mem_rdata right by 8*offset, take the low bytes(size) bytes, then sign-extend, or zero-extend when req_unsigned=1; the result is registered when mem_ack is sampled.
REQ-024 Timeout: when TIMEOUT > 0 and mem_ack has not been seen after TIMEOUT cycles in MEM, the block SHALL drop mem_req and go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-025 RESP: rsp_valid SHALL be 1 for exactly one cycle (no backpressure), then the block returns to IDLE.
REQ-026 For stores and for all errors, rsp_rdata SHALL be 0.
REQ-027 Minimum latency: with mem_ack high in the first mem_req cycle, rsp_valid SHALL assert 2 cycles after the acceptance edge; peak throughput is one request per 3 cycles.
REQ-028 A mem_ack sampled outside MEM SHALL be ignored.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE and clear the timeout counter, including in the middle of an access.
REQ-030 During reset, outputs SHALL be: req_ready=0; rsp_valid, rsp_err, mem_req, mem_we, busy = 0; mem_addr, mem_be, mem_wdata, rsp_rdata = 0.
REQ-031 req_ready SHALL rise in the first cycle after reset is released.

Structure
REQ-032 Shared package lsu_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the state encoding.
REQ-033 A combinational sub-module lsu_align SHALL hold the lane shift, byte-enable generation and sign/zero-extension logic; the FSM and the timeout counter stay in lsu.

Verification
REQ-034 LW at addr 0x100, mem_rdata=0xDEADBEEF, ack on the first cycle -> mem_be=0xF, mem_addr=0x100; rsp_valid 2 cycles after accept; rsp_rdata=0xDEADBEEF, err=0.
REQ-035 LB at 0x103 (signed), then LBU at 0x103, mem_rdata=0x80FFFFFF -> rsp_rdata 0xFFFFFF80 then 0x00000080; mem_be=0x8.
REQ-036 SH at 0x202, wdata=0x1234 -> mem_addr=0x200, mem_be=0xC, mem_wdata=0x12340000, mem_we=1; rsp_rdata=0.
REQ-037 LW at 0x101 -> mem_req never asserts; a single rsp_valid with rsp_err=1.
REQ-038 TIMEOUT=4, mem_ack held low -> mem_req high for 4 cycles then low; rsp_err=1, rsp_rdata=0.
REQ-039 reset pulled low 2 cycles into a MEM wait -> mem_req=0 at once; after release, req_ready=1 and the next LW completes normally.
